note_lane: RTL and testbench

Parametrised single-lane note dropper for the rhythm game. It is the generalised successor of the fixed one-shot arrow dropper: it launches a schedule of `NUM_NOTES` notes down one lane and grades each key press as perfect, good or miss. It keeps hit, miss and combo counters, and exports position, visibility and sprite direction to the renderer. The sprite bitmap is not generated here. One instance sits per lane (×4) between the keycode decoder and the VGA colour mapper, clocked by `frame_clk` (once per video frame).

---
 rtl/rhythm_pkg.sv | 32 +++
 rtl/note_lane_if.sv | 36 +++
 rtl/note_lane_key_edge_detect.sv | 27 ++
 rtl/note_lane.sv | 187 ++++++++++++++++++
 tb/tb_note_lane.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rhythm_pkg.sv
// Shared types, keycodes and score helpers for the rhythm game lanes.
package rhythm_pkg;

    typedef enum logic [1:0] {
        HALTED,
        WAIT,
        FALL,
        DONE
    } lane_state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    localparam logic [7:0] KEY_START   = 8'h2c;
    localparam logic [7:0] KEY_RESTART = 8'h01;
    localparam logic [7:0] KEY_UP      = 8'h52;
    localparam logic [7:0] KEY_DOWN    = 8'h51;
    localparam logic [7:0] KEY_LEFT    = 8'h50;
    localparam logic [7:0] KEY_RIGHT   = 8'h4f;

    localparam int SCORE_W = 8;

    // Score counters stick at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/note_lane_if.sv
// Lane bundle: keycodes in from the decoder, render and score state out.
interface note_lane_if;
    import rhythm_pkg::*;

    logic [7:0]         keycode;
    logic [7:0]         keycode_second;
    logic [9:0]         dropX;
    logic [9:0]         dropY;
    logic               visible;
    logic [1:0]         dir;
    logic               hit_pulse;
    logic               perfect_pulse;
    logic               miss_pulse;
    logic [SCORE_W-1:0] hit_count;
    logic [SCORE_W-1:0] miss_count;
    logic [SCORE_W-1:0] combo;
    logic [SCORE_W-1:0] max_combo;
    logic               lane_done;

    // Lane side.
    modport master (
        input  keycode, keycode_second,
        output dropX, dropY, visible, dir,
        output hit_pulse, perfect_pulse, miss_pulse,
        output hit_count, miss_count, combo, max_combo, lane_done
    );

    // Decoder / renderer side.
    modport slave (
        output keycode, keycode_second,
        input  dropX, dropY, visible, dir,
        input  hit_pulse, perfect_pulse, miss_pulse,
        input  hit_count, miss_count, combo, max_combo, lane_done
    );

endinterface

// File: rtl/note_lane_key_edge_detect.sv
// Detects a lane key on either keycode slot and flags its first frame.
module key_edge_detect #(
    parameter logic [7:0] KEY = 8'h52
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] keycode_second,
    output logic       pressed,
    output logic       press_edge
);

    logic pressed_q;

    assign pressed    = (keycode == KEY) || (keycode_second == KEY);
    assign press_edge = pressed && !pressed_q;

    // Remember last frame's key level so a held key yields a single edge.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            pressed_q <= 1'b0;
        end else begin
            pressed_q <= pressed;
        end
    end

endmodule

// File: rtl/note_lane.sv
// One rhythm-game lane: schedules notes, moves them down, grades key presses.
module note_lane
    import rhythm_pkg::*;
#(
    parameter int         X_POS        = 440,
    parameter int         Y_START      = 100,
    parameter int         Y_MAX        = 400,
    parameter int         SPRITE_H     = 40,
    parameter int         HIT_LO       = 340,
    parameter int         PERF_LO      = 370,
    parameter int         PERF_HI      = 390,
    parameter int         SPEED        = 1,
    parameter int         NUM_NOTES    = 4,
    parameter int         FIRST_LAUNCH = 16,
    parameter int         LAUNCH_GAP   = 300,
    parameter logic [7:0] HIT_KEY      = 8'h52,
    parameter dir_t       DIR          = DIR_UP
) (
    input  logic        frame_clk,
    input  logic        Reset,
    note_lane_if.master lane
);

    lane_state_t        state, state_n;
    logic [11:0]        frame_cnt, frame_cnt_n, frame_inc;
    logic [7:0]         note_idx, note_idx_n;
    logic [9:0]         drop_y, drop_y_n;
    logic               visible, visible_n;
    logic               hit_p, hit_p_n;
    logic               perf_p, perf_p_n;
    logic               miss_p, miss_p_n;
    logic [SCORE_W-1:0] hit_cnt, hit_cnt_n;
    logic [SCORE_W-1:0] miss_cnt, miss_cnt_n;
    logic [SCORE_W-1:0] combo, combo_n, combo_inc;
    logic [SCORE_W-1:0] max_combo, max_combo_n;
    logic               done, done_n;
    logic [9:0]         drop_x;
    logic [1:0]         dir_q;

    logic [10:0]        bottom;
    logic [31:0]        launch_at;
    logic               start_key, restart_key;
    logic               hit_edge, unused_hit_level;

    key_edge_detect #(.KEY(HIT_KEY)) u_hit_key (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (lane.keycode),
        .keycode_second (lane.keycode_second),
        .pressed        (unused_hit_level),
        .press_edge     (hit_edge)
    );

    assign start_key   = (lane.keycode == KEY_START)   || (lane.keycode_second == KEY_START);
    assign restart_key = (lane.keycode == KEY_RESTART) || (lane.keycode_second == KEY_RESTART);

    assign bottom    = {1'b0, drop_y} + 11'(SPRITE_H);
    assign frame_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;
    assign launch_at = 32'(FIRST_LAUNCH) + 32'(note_idx) * 32'(LAUNCH_GAP);
    assign combo_inc = sat_inc(combo);

    // Next-state and next-output logic for the lane sequencer.
    always_comb begin
        state_n     = state;
        frame_cnt_n = frame_cnt;
        note_idx_n  = note_idx;
        drop_y_n    = drop_y;
        visible_n   = visible;
        hit_p_n     = 1'b0;
        perf_p_n    = 1'b0;
        miss_p_n    = 1'b0;
        hit_cnt_n   = hit_cnt;
        miss_cnt_n  = miss_cnt;
        combo_n     = combo;
        max_combo_n = max_combo;

        unique case (state)
            HALTED: begin
                if (start_key) state_n = WAIT;
            end
            WAIT: begin
                frame_cnt_n = frame_inc;
                // >= lets a launch that fell due during the previous note fire late.
                if (32'(frame_inc) >= launch_at) begin
                    drop_y_n  = 10'(Y_START);
                    visible_n = 1'b1;
                    state_n   = FALL;
                end
            end
            FALL: begin
                frame_cnt_n = frame_inc;
                if (bottom >= 11'(Y_MAX) || (hit_edge && bottom >= 11'(HIT_LO))) begin
                    // Miss is tested first so a press on the miss frame still misses.
                    if (bottom >= 11'(Y_MAX)) begin
                        miss_p_n   = 1'b1;
                        miss_cnt_n = sat_inc(miss_cnt);
                        combo_n    = '0;
                    end else begin
                        hit_p_n     = 1'b1;
                        perf_p_n    = (bottom >= 11'(PERF_LO)) && (bottom < 11'(PERF_HI));
                        hit_cnt_n   = sat_inc(hit_cnt);
                        combo_n     = combo_inc;
                        max_combo_n = (combo_inc > max_combo) ? combo_inc : max_combo;
                    end
                    visible_n = 1'b0;
                    if (note_idx == 8'(NUM_NOTES - 1)) begin
                        state_n = DONE;
                    end else begin
                        note_idx_n = note_idx + 1'b1;
                        state_n    = WAIT;
                    end
                end else begin
                    drop_y_n = drop_y + 10'(SPEED);
                end
            end
            DONE: begin
                if (restart_key) state_n = HALTED;
            end
            default: state_n = HALTED;
        endcase

        // Entering or sitting in HALTED always presents the cleared lane.
        if (state_n == HALTED) begin
            frame_cnt_n = '0;
            note_idx_n  = '0;
            drop_y_n    = 10'(Y_START);
            visible_n   = 1'b0;
            hit_cnt_n   = '0;
            miss_cnt_n  = '0;
            combo_n     = '0;
            max_combo_n = '0;
        end

        done_n = (state_n == DONE);
    end

    // Register every state bit and output; reset overrides everything.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state     <= HALTED;
            frame_cnt <= '0;
            note_idx  <= '0;
            drop_y    <= 10'(Y_START);
            visible   <= 1'b0;
            hit_p     <= 1'b0;
            perf_p    <= 1'b0;
            miss_p    <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            combo     <= '0;
            max_combo <= '0;
            done      <= 1'b0;
            drop_x    <= 10'(X_POS);
            dir_q     <= DIR;
        end else begin
            state     <= state_n;
            frame_cnt <= frame_cnt_n;
            note_idx  <= note_idx_n;
            drop_y    <= drop_y_n;
            visible   <= visible_n;
            hit_p     <= hit_p_n;
            perf_p    <= perf_p_n;
            miss_p    <= miss_p_n;
            hit_cnt   <= hit_cnt_n;
            miss_cnt  <= miss_cnt_n;
            combo     <= combo_n;
            max_combo <= max_combo_n;
            done      <= done_n;
            drop_x    <= 10'(X_POS);
            dir_q     <= DIR;
        end
    end

    assign lane.dropX         = drop_x;
    assign lane.dropY         = drop_y;
    assign lane.visible       = visible;
    assign lane.dir           = dir_q;
    assign lane.hit_pulse     = hit_p;
    assign lane.perfect_pulse = perf_p;
    assign lane.miss_pulse    = miss_p;
    assign lane.hit_count     = hit_cnt;
    assign lane.miss_count    = miss_cnt;
    assign lane.combo         = combo;
    assign lane.max_combo     = max_combo;
    assign lane.lane_done     = done;

endmodule

// File: tb/tb_note_lane.sv
// Directed bench for note_lane with default parameters.
module tb_note_lane;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    note_lane_if bus ();

    note_lane dut (
        .frame_clk (clk),
        .Reset     (rst),
        .lane      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_drop(input int y, input string tag);
        int n = 0;
        while (!(bus.visible === 1'b1 && bus.dropY === 10'(y)) && n < 1500) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 1500), 32'd1);
    endtask

    task automatic wait_miss(input string tag);
        int n = 0;
        while (bus.miss_pulse !== 1'b1 && n < 1500) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 1500), 32'd1);
    endtask

    task automatic press(input logic second);
        if (second) bus.keycode_second = 8'h52;
        else        bus.keycode        = 8'h52;
        tick();
    endtask

    task automatic release_keys();
        bus.keycode        = 8'h00;
        bus.keycode_second = 8'h00;
        tick();
    endtask

    initial begin
        int misses;
        int n;
        logic [9:0] first_miss_y;

        bus.keycode        = 8'h00;
        bus.keycode_second = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_dropX", 32'(bus.dropX), 32'd440);
        check("rst_dropY", 32'(bus.dropY), 32'd100);
        check("rst_dir", 32'(bus.dir), 32'd0);
        check("rst_visible", 32'(bus.visible), 32'd0);
        check("rst_pulses", 32'({bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse}), 32'd0);
        check("rst_counts", {bus.hit_count, bus.miss_count, bus.combo, bus.max_combo}, 32'd0);
        check("rst_done", 32'(bus.lane_done), 32'd0);
        for (int i = 0; i < 30; i++) tick();
        check("halted_idle", 32'(bus.visible), 32'd0);

        // Song 1: no presses, every note misses
        bus.keycode = 8'h2c;
        tick();
        bus.keycode = 8'h00;
        for (int i = 0; i < 15; i++) tick();
        check("pre_launch_visible", 32'(bus.visible), 32'd0);
        tick();
        check("launch_visible", 32'(bus.visible), 32'd1);
        check("launch_dropY", 32'(bus.dropY), 32'd100);
        tick();
        check("fall_step", 32'(bus.dropY), 32'd101);

        misses = 0;
        n = 0;
        first_miss_y = '0;
        while (bus.lane_done !== 1'b1 && n < 1500) begin
            if (bus.miss_pulse === 1'b1) begin
                if (misses == 0) first_miss_y = bus.dropY;
                misses++;
            end
            tick();
            n++;
        end
        if (bus.miss_pulse === 1'b1) misses++;
        check("song1_done_in_time", 32'(n < 1500), 32'd1);
        check("song1_miss_pulses", 32'(misses), 32'd4);
        check("song1_miss_line_y", 32'(first_miss_y), 32'd360);
        check("song1_miss_count", 32'(bus.miss_count), 32'd4);
        check("song1_hit_count", 32'(bus.hit_count), 32'd0);
        check("song1_visible", 32'(bus.visible), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("song1_done_holds", 32'(bus.lane_done), 32'd1);

        bus.keycode = 8'h01;
        tick();
        bus.keycode = 8'h00;
        check("restart_done", 32'(bus.lane_done), 32'd0);
        check("restart_miss_count", 32'(bus.miss_count), 32'd0);
        check("restart_dropY", 32'(bus.dropY), 32'd100);

        // Song 2: hit (perfect), hit (good), early press then miss, hit
        bus.keycode = 8'h2c;
        tick();
        bus.keycode = 8'h00;

        wait_drop(335, "n0_reach_335");
        press(1'b0);
        check("n0_hit", 32'(bus.hit_pulse), 32'd1);
        check("n0_perfect", 32'(bus.perfect_pulse), 32'd1);
        check("n0_combo", 32'(bus.combo), 32'd1);
        check("n0_visible", 32'(bus.visible), 32'd0);
        check("n0_dropY_hold", 32'(bus.dropY), 32'd335);
        release_keys();
        check("n0_pulse_one_frame", 32'(bus.hit_pulse), 32'd0);
        press(1'b0);
        release_keys();
        check("wait_press_combo", 32'(bus.combo), 32'd1);
        check("wait_press_hits", 32'(bus.hit_count), 32'd1);

        wait_drop(305, "n1_reach_305");
        press(1'b0);
        check("n1_hit", 32'(bus.hit_pulse), 32'd1);
        check("n1_not_perfect", 32'(bus.perfect_pulse), 32'd0);
        check("n1_combo", 32'(bus.combo), 32'd2);
        check("n1_max_combo", 32'(bus.max_combo), 32'd2);
        release_keys();

        wait_drop(250, "n2_reach_250");
        press(1'b0);
        check("n2_early_no_hit", 32'(bus.hit_pulse), 32'd0);
        check("n2_early_visible", 32'(bus.visible), 32'd1);
        check("n2_early_combo", 32'(bus.combo), 32'd2);
        release_keys();
        wait_miss("n2_miss_seen");
        check("n2_combo_cleared", 32'(bus.combo), 32'd0);
        check("n2_miss_count", 32'(bus.miss_count), 32'd1);

        wait_drop(340, "n3_reach_340");
        press(1'b0);
        check("n3_hit", 32'(bus.hit_pulse), 32'd1);
        check("n3_perfect", 32'(bus.perfect_pulse), 32'd1);
        check("n3_combo", 32'(bus.combo), 32'd1);
        check("n3_max_combo", 32'(bus.max_combo), 32'd2);
        check("n3_hit_count", 32'(bus.hit_count), 32'd3);
        check("n3_done", 32'(bus.lane_done), 32'd1);
        release_keys();

        bus.keycode = 8'h01;
        tick();
        bus.keycode = 8'h00;

        // Song 3: held key never scores, fresh press on second slot does, then reset mid-fall
        bus.keycode        = 8'h2c;
        bus.keycode_second = 8'h52;
        tick();
        bus.keycode = 8'h00;
        wait_miss("held_miss_seen");
        check("held_no_hit", 32'(bus.hit_count), 32'd0);
        check("held_miss_count", 32'(bus.miss_count), 32'd1);
        release_keys();

        wait_drop(305, "n1b_reach_305");
        press(1'b1);
        check("n1b_hit", 32'(bus.hit_pulse), 32'd1);
        check("n1b_hit_count", 32'(bus.hit_count), 32'd1);
        release_keys();

        wait_drop(200, "n2b_reach_200");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_visible", 32'(bus.visible), 32'd0);
        check("midrst_dropY", 32'(bus.dropY), 32'd100);
        check("midrst_pulses", 32'({bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse}), 32'd0);
        check("midrst_counts", {bus.hit_count, bus.miss_count, bus.combo, bus.max_combo}, 32'd0);
        for (int i = 0; i < 40; i++) tick();
        check("midrst_stays_halted", 32'(bus.visible), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
